// File: rtl/pixel_pkg.sv
// Shared pixel types and fixed colours for the display compositor.
// XVGA active-area defaults live here so the top and the bench agree on them.
package pixel_pkg;
  typedef logic [23:0] rgb_t;

  localparam rgb_t GRAB_RGB   = 24'hFFFF00;
  localparam rgb_t PLAYER_RGB = 24'hFFFFFF;
  localparam rgb_t WALL_RGB   = 24'h00FFFF;
  localparam rgb_t GOAL_RGB   = 24'h000000;

  localparam int XVGA_H_ACTIVE = 1024;
  localparam int XVGA_V_ACTIVE = 768;
endpackage

// File: rtl/disc_hit.sv
// Disc membership test: registered offset from centre, then registered squared-distance < R2.
// Latency 2 cycles, free-running, no backpressure.
module disc_hit #(
  parameter int R2 = 150
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [10:0] x_i,
  input  logic [9:0]  y_i,
  input  logic [10:0] cx_i,
  input  logic [9:0]  cy_i,
  output logic        hit_o
);
  logic signed [11:0] dx_q, dx_d, dy_q, dy_d;
  logic signed [23:0] dx_w, dy_w;
  logic [23:0]        sqx, sqy;
  logic [24:0]        sum;
  logic               hit_q, hit_d;

  assign dx_d = $signed({1'b0, x_i}) - $signed({1'b0, cx_i});
  assign dy_d = $signed({2'b0, y_i}) - $signed({2'b0, cy_i});

  // Widen before multiplying so the square is not truncated to the operand width.
  assign dx_w  = {{12{dx_q[11]}}, dx_q};
  assign dy_w  = {{12{dy_q[11]}}, dy_q};
  assign sqx   = dx_w * dx_w;
  assign sqy   = dy_w * dy_w;
  assign sum   = {1'b0, sqx} + {1'b0, sqy};
  assign hit_d = sum < 25'(R2);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dx_q  <= '0;
      dy_q  <= '0;
      hit_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;
endmodule

// File: rtl/pixel_compositor.sv
// Per-pixel compositor: hands > player > wall > goal > gradient > background; 3-cycle latency, no backpressure.
// Define CURSOR_BLINK_EN to make grabbing hands blink every BLINK_FRAMES vsync falls.
module pixel_compositor
  import pixel_pkg::*;
#(
  parameter int                      NUM_HANDS    = 2,
  parameter int                      HAND_R2      = 150,
  parameter int                      PLAYER_R2    = 200,
  parameter int                      H_ACTIVE     = XVGA_H_ACTIVE,
  parameter int                      V_ACTIVE     = XVGA_V_ACTIVE,
  parameter int                      GRAD_SHIFT   = 11,
  parameter rgb_t                    BG_COLOR     = 24'hAA8833,
  parameter int                      GOAL_Y       = -2384,
  parameter logic [24*NUM_HANDS-1:0] HAND_COLORS  = {24'hFF0000, 24'h00FF00},
  parameter rgb_t                    GRAB_COLOR   = GRAB_RGB,
  parameter int                      BLINK_FRAMES = 8
) (
  input  logic                     clockin,
  input  logic                     reset,
  input  logic [10:0]              hcount,
  input  logic [9:0]               vcount,
  input  logic                     hsync,
  input  logic                     vsync,
  input  logic                     blank,
  input  logic [11*NUM_HANDS-1:0]  hand_x,
  input  logic [10*NUM_HANDS-1:0]  hand_y,
  input  logic [NUM_HANDS-1:0]     grab,
  input  logic                     exists,
  input  logic signed [12:0]       screeny,
  output rgb_t                     pixel,
  output logic                     pclock,
  output logic                     phsync,
  output logic                     pvsync,
  output logic                     pblank
);
  localparam int PW = 8 + GRAD_SHIFT;

  logic [2:0]            tim_s1_q, tim_s2_q, tim_q;
  logic                  exists_s1_q, exists_s2_q;
  logic [NUM_HANDS-1:0]  grab_s1_q, grab_s2_q, hand_hit, show_grab;
  logic signed [14:0]    w_s1_q, w_d, d_s1_q, d_d;
  logic                  goal_s2_q, goal_d, grad_ok_s2_q, grad_ok_d, player_hit;
  rgb_t                  grad_s2_q, grad_d, pixel_q, pixel_d;
  logic [GRAD_SHIFT-1:0] d_low;

  for (genvar i = 0; i < NUM_HANDS; i++) begin : g_hand
    disc_hit #(.R2(HAND_R2)) u_hit (
      .clk_i (clockin),
      .rst_i (reset),
      .x_i   (hcount),
      .y_i   (vcount),
      .cx_i  (hand_x[11*i +: 11]),
      .cy_i  (hand_y[10*i +: 10]),
      .hit_o (hand_hit[i])
    );
  end

  disc_hit #(.R2(PLAYER_R2)) u_player (
    .clk_i (clockin),
    .rst_i (reset),
    .x_i   (hcount),
    .y_i   (vcount),
    .cx_i  (11'(H_ACTIVE / 2)),
    .cy_i  (10'(V_ACTIVE / 2)),
    .hit_o (player_hit)
  );

  assign w_d = $signed({5'b0, vcount}) + $signed({{2{screeny[12]}}, screeny});
  assign d_d = $signed(15'(V_ACTIVE)) - w_d;

  assign goal_d    = (w_s1_q >= $signed(15'(GOAL_Y - 1))) && (w_s1_q <= $signed(15'(GOAL_Y + 1)));
  assign grad_ok_d = !d_s1_q[14] && (d_s1_q < $signed(15'(2 ** GRAD_SHIFT)));

  // Only the low GRAD_SHIFT bits of d matter whenever the gradient is actually selected.
  assign d_low = d_s1_q[GRAD_SHIFT-1:0];
  for (genvar c = 0; c < 3; c++) begin : g_grad
    logic [PW-1:0] prod;
    assign prod = PW'(BG_COLOR[8*c +: 8]) * PW'(d_low);
    assign grad_d[8*c +: 8] = prod[PW-1 -: 8];
  end

`ifdef CURSOR_BLINK_EN
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FCW-1:0] frame_q, frame_d;
  logic           blink_q, blink_d, vs_fall;

  assign vs_fall = tim_s1_q[1] & ~vsync;

  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (vs_fall) begin
      if (frame_q == FCW'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        blink_d = ~blink_q;
      end else begin
        frame_d = frame_q + FCW'(1);
      end
    end
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      frame_q <= '0;
      blink_q <= 1'b1;
    end else begin
      frame_q <= frame_d;
      blink_q <= blink_d;
    end
  end

  assign show_grab = grab_s2_q & {NUM_HANDS{blink_q}};
`else
  assign show_grab = grab_s2_q;
`endif

  // Assigned lowest priority first so later matches override; hand 0 ends up on top.
  always_comb begin
    pixel_d = BG_COLOR;
    if (grad_ok_s2_q) pixel_d = grad_s2_q;
    if (goal_s2_q)    pixel_d = GOAL_RGB;
    if (exists_s2_q)  pixel_d = WALL_RGB;
    if (player_hit)   pixel_d = PLAYER_RGB;
    for (int i = NUM_HANDS - 1; i >= 0; i--) begin
      if (hand_hit[i]) pixel_d = show_grab[i] ? GRAB_COLOR : HAND_COLORS[24*i +: 24];
    end
  end

  always_ff @(posedge clockin) begin
    if (reset) begin
      tim_s1_q     <= 3'b111;
      tim_s2_q     <= 3'b111;
      tim_q        <= 3'b111;
      exists_s1_q  <= 1'b0;
      exists_s2_q  <= 1'b0;
      grab_s1_q    <= '0;
      grab_s2_q    <= '0;
      w_s1_q       <= '0;
      d_s1_q       <= '0;
      goal_s2_q    <= 1'b0;
      grad_ok_s2_q <= 1'b0;
      grad_s2_q    <= '0;
      pixel_q      <= '0;
    end else begin
      tim_s1_q     <= {hsync, vsync, blank};
      tim_s2_q     <= tim_s1_q;
      tim_q        <= tim_s2_q;
      exists_s1_q  <= exists;
      exists_s2_q  <= exists_s1_q;
      grab_s1_q    <= grab;
      grab_s2_q    <= grab_s1_q;
      w_s1_q       <= w_d;
      d_s1_q       <= d_d;
      goal_s2_q    <= goal_d;
      grad_ok_s2_q <= grad_ok_d;
      grad_s2_q    <= grad_d;
      pixel_q      <= pixel_d;
    end
  end

  assign pixel  = pixel_q;
  assign pclock = clockin;
  assign phsync = tim_q[2];
  assign pvsync = tim_q[1];
  assign pblank = tim_q[0];
endmodule

// File: tb/tb_pixel_compositor.sv
// Randomised and directed stimulus for pixel_compositor, checked by a scoreboard against a geometric model.
module tb_pixel_compositor;
  localparam int NH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic [10:0]        hcount;
  logic [9:0]         vcount;
  logic               hsync, vsync, blank;
  logic [11*NH-1:0]   hand_x;
  logic [10*NH-1:0]   hand_y;
  logic [NH-1:0]      grab;
  logic               exists;
  logic signed [12:0] screeny;
  logic [23:0]        pixel;
  logic               pclock, phsync, pvsync, pblank;

  pixel_compositor dut (
    .clockin (clk),
    .reset   (reset),
    .hcount  (hcount),
    .vcount  (vcount),
    .hsync   (hsync),
    .vsync   (vsync),
    .blank   (blank),
    .hand_x  (hand_x),
    .hand_y  (hand_y),
    .grab    (grab),
    .exists  (exists),
    .screeny (screeny),
    .pixel   (pixel),
    .pclock  (pclock),
    .phsync  (phsync),
    .pvsync  (pvsync),
    .pblank  (pblank)
  );

  typedef struct {
    logic [23:0] pix;
    logic [2:0]  tim;
    bit          care;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_count;
  bit   m_phase;
  bit   m_prev_vs;

  function automatic logic [23:0] hand_col(input int i);
    return (i == 0) ? 24'h00FF00 : 24'hFF0000;
  endfunction

  // Colour of the current input pixel from the geometric rules, top layer first.
  function automatic logic [23:0] model_pix();
    int dx, dy, w, d;
    bit g;
    for (int i = 0; i < NH; i++) begin
      dx = int'(hcount) - int'(hand_x[11*i +: 11]);
      dy = int'(vcount) - int'(hand_y[10*i +: 10]);
      if (dx * dx + dy * dy < 150) begin
`ifdef CURSOR_BLINK_EN
        g = grab[i] && m_phase;
`else
        g = grab[i];
`endif
        return g ? 24'hFFFF00 : hand_col(i);
      end
    end
    dx = int'(hcount) - 512;
    dy = int'(vcount) - 384;
    if (dx * dx + dy * dy < 200) return 24'hFFFFFF;
    if (exists) return 24'h00FFFF;
    w = int'(vcount) + int'(screeny);
    if (w >= -2385 && w <= -2383) return 24'h000000;
    d = 768 - w;
    if (d >= 0 && d < 2048)
      return {8'((170 * d) >> 11), 8'((136 * d) >> 11), 8'((51 * d) >> 11)};
    return 24'hAA8833;
  endfunction

  task automatic step(input bit care);
    exp_t e;
    if (m_prev_vs && !vsync) begin
      m_count++;
      if (m_count == 8) begin
        m_count = 0;
        m_phase = ~m_phase;
      end
    end
    m_prev_vs = vsync;
    e.pix  = model_pix();
    e.tim  = {hsync, vsync, blank};
    e.care = care;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_hand(input int i, input int x, input int y);
    hand_x[11*i +: 11] = 11'(x);
    hand_y[10*i +: 10] = 10'(y);
  endtask

  task automatic pix(input int x, input int y);
    hcount = 11'(x);
    vcount = 10'(y);
    step(1'b1);
  endtask

  task automatic do_reset(input int n);
    sb.delete();
    reset  = 1'b1;
    hsync  = 1'b0;
    vsync  = 1'b0;
    blank  = 1'b0;
    hcount = 11'd512;
    vcount = 10'd384;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (pixel !== 24'h0 || {phsync, pvsync, pblank} !== 3'b111 || pclock !== clk) begin
        errors++;
        $display("FAIL reset_state cycle %0d: pixel=%h syncs=%b pclock=%b, want pixel=000000 syncs=111 pclock=%b",
                 i, pixel, {phsync, pvsync, pblank}, pclock, clk);
      end
    end
    hsync     = 1'b1;
    vsync     = 1'b1;
    blank     = 1'b1;
    m_count   = 0;
    m_phase   = 1'b1;
    m_prev_vs = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Output seen now belongs to the stimulus issued three steps ago.
  always @(negedge clk) begin
    if (sb.size() > 3) begin
      mon_e = sb.pop_front();
      checks++;
      if ({phsync, pvsync, pblank} !== mon_e.tim) begin
        errors++;
        $display("FAIL timing_delay: got %b, want %b at %0t", {phsync, pvsync, pblank}, mon_e.tim, $time);
      end
      if (mon_e.care) begin
        checks++;
        if (pixel !== mon_e.pix) begin
          errors++;
          $display("FAIL pixel_colour: got %h, want %h at %0t", pixel, mon_e.pix, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int ox, oy;

  initial begin
    reset   = 1'b1;
    hcount  = '0;
    vcount  = '0;
    hsync   = 1'b1;
    vsync   = 1'b1;
    blank   = 1'b1;
    grab    = '0;
    exists  = 1'b0;
    screeny = '0;
    set_hand(0, 900, 700);
    set_hand(1, 950, 50);

    do_reset(5);
    pix(512, 384);
    pix(512, 398);
    pix(526, 384);

    set_hand(0, 100, 100);
    pix(105, 105);
    pix(112, 100);
    pix(113, 100);
    pix(100, 88);

    set_hand(0, 300, 300);
    set_hand(1, 300, 300);
    grab = 2'b10;
    pix(300, 300);
    grab = 2'b11;
    pix(305, 300);
    grab = 2'b00;
    set_hand(0, 900, 700);
    set_hand(1, 950, 50);

    screeny = 13'sd0;     pix(50, 0);
    screeny = -13'sd1300; pix(50, 0);
    screeny = -13'sd1280; pix(50, 0);
    screeny = -13'sd1279; pix(50, 0);
    screeny = 13'sd0;     pix(50, 768);
    screeny = 13'sd0;     pix(50, 800);

    screeny = -13'sd2400;
    for (int v = 14; v <= 18; v++) pix(50, v);
    exists = 1'b1;
    for (int v = 15; v <= 17; v++) pix(50, v);
    exists = 1'b0;

    screeny = 13'sd0;
    set_hand(0, 0, 0);
    pix(0, 5);
    pix(2047, 0);
    pix(5, 1023);
    set_hand(0, 1023, 767);
    pix(1023, 767);
    pix(1030, 767);

    set_hand(0, 600, 600);
    grab   = 2'b01;
    hcount = 11'd600;
    vcount = 10'd600;
    for (int f = 0; f < 20; f++) begin
      vsync = 1'b0;
      step(1'b0);
      vsync = 1'b1;
      for (int s = 1; s <= 10; s++) step(s >= 4 && s <= 7);
    end
    grab = 2'b00;

    for (int n = 0; n < 1500; n++) begin
      hcount = 11'($urandom_range(0, 1023));
      vcount = 10'($urandom_range(0, 767));
      for (int i = 0; i < NH; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          ox = int'($urandom_range(0, 30)) - 15;
          oy = int'($urandom_range(0, 30)) - 15;
          set_hand(i, int'(hcount) + ox, int'(vcount) + oy);
        end else begin
          set_hand(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)));
        end
      end
      if ($urandom_range(0, 3) == 0)
        screeny = 13'(-2384 - int'(vcount) + int'($urandom_range(0, 4)) - 2);
      else
        screeny = 13'($urandom_range(0, 8191));
      grab   = 2'($urandom_range(0, 3));
      exists = ($urandom_range(0, 7) == 0);
      hsync  = 1'($urandom_range(0, 1));
      blank  = 1'($urandom_range(0, 1));
      step(1'b1);
    end

    do_reset(2);
    set_hand(0, 900, 700);
    set_hand(1, 950, 50);
    grab    = '0;
    exists  = 1'b0;
    screeny = '0;
    pix(512, 384);
    pix(50, 0);
    pix(50, 768);
    for (int i = 0; i < 4; i++) pix(50, 100);

    checks++;
    if (checks < 1000) begin
      errors++;
      $display("FAIL check_count: got %0d, want at least 1000", checks);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
